// File: rtl/wb_interconnect_pkg.sv
// Shared types and helpers for the Wishbone interconnect blocks.
// Holds the router state encoding and an offset helper for flattened
// per-port vectors (port k occupies [k*width +: width]).
package wb_interconnect_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERR    = 2'd2
  } state_t;

  // Low bit index of port idx inside a flattened vector of width-bit fields.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/wb_interconnect_tgt_sel_if.sv
// Bus bundle for the target-select router: the granted initiator's
// classic-cycle signals plus the flattened per-target signals.
// master: the initiator and targets side; slave: the router itself.
interface wb_interconnect_tgt_sel_if #(
  parameter int N_TGT = 2,
  parameter int ADR_W = 32,
  parameter int DAT_W = 32
);
  localparam int SEL_W = DAT_W / 8;

  // initiator side
  logic [ADR_W-1:0]         i_adr;
  logic [DAT_W-1:0]         i_dat_w;
  logic [DAT_W-1:0]         i_dat_r;
  logic                     i_cyc;
  logic                     i_stb;
  logic                     i_we;
  logic [SEL_W-1:0]         i_sel;
  logic                     i_ack;
  logic                     i_err;

  // target side, flattened per port
  logic [N_TGT*ADR_W-1:0]   t_adr;
  logic [N_TGT*DAT_W-1:0]   t_dat_w;
  logic [N_TGT*DAT_W-1:0]   t_dat_r;
  logic [N_TGT-1:0]         t_cyc;
  logic [N_TGT-1:0]         t_stb;
  logic [N_TGT-1:0]         t_we;
  logic [N_TGT*SEL_W-1:0]   t_sel;
  logic [N_TGT-1:0]         t_ack;
  logic [N_TGT-1:0]         t_err;

  modport master (
    output i_adr, i_dat_w, i_cyc, i_stb, i_we, i_sel,
    input  i_dat_r, i_ack, i_err,
    input  t_adr, t_dat_w, t_cyc, t_stb, t_we, t_sel,
    output t_dat_r, t_ack, t_err
  );

  modport slave (
    input  i_adr, i_dat_w, i_cyc, i_stb, i_we, i_sel,
    output i_dat_r, i_ack, i_err,
    output t_adr, t_dat_w, t_cyc, t_stb, t_we, t_sel,
    input  t_dat_r, t_ack, t_err
  );

endinterface

// File: rtl/wb_interconnect_adr_dec.sv
// Combinational address decoder: compares an address against every
// target's base/mask window and returns a one-hot select (lowest
// matching index wins) plus a hit flag. Kept standalone so a future
// multi-initiator crossbar can reuse it per initiator.
module wb_interconnect_adr_dec #(
  parameter int                     N_TGT      = 2,
  parameter int                     ADR_W      = 32,
  parameter logic [N_TGT*ADR_W-1:0] T_ADR      = '0,
  parameter logic [N_TGT*ADR_W-1:0] T_ADR_MASK = '0
) (
  input  logic [ADR_W-1:0] adr,
  output logic [N_TGT-1:0] sel,
  output logic             hit
);

  logic [N_TGT-1:0] match;

  for (genvar gi = 0; gi < N_TGT; gi++) begin : g_match
    localparam logic [ADR_W-1:0] BASE = T_ADR[gi*ADR_W +: ADR_W];
    localparam logic [ADR_W-1:0] MASK = T_ADR_MASK[gi*ADR_W +: ADR_W];
    assign match[gi] = ((adr & MASK) == (BASE & MASK));
  end

  // Isolate the lowest set bit so overlapping windows resolve to one target.
  assign sel = match & (~match + N_TGT'(1));
  assign hit = |match;

endmodule

// File: rtl/wb_interconnect_tgt_sel.sv
// Single-initiator to N-target Wishbone router. Decodes the granted
// initiator's address, forwards the cycle to the selected target and
// returns its ack/err/read data combinationally; unmapped addresses get
// a one-cycle error response.
// Optional build macro WB_INTERCONNECT_TGT_SEL_TIMEOUT_EN: errors out an
// access that no target answers within TIMEOUT cycles.
module wb_interconnect_tgt_sel
  import wb_interconnect_pkg::*;
#(
  parameter int                     N_TGT      = 2,
  parameter int                     ADR_W      = 32,
  parameter int                     DAT_W      = 32,
  parameter logic [N_TGT*ADR_W-1:0] T_ADR      = '0,
  parameter logic [N_TGT*ADR_W-1:0] T_ADR_MASK = '0,
  parameter int                     TIMEOUT    = 256
) (
  input logic                      clk,
  input logic                      rst,
  wb_interconnect_tgt_sel_if.slave bus
);

  localparam int SEL_W = DAT_W / 8;

  state_t           state_reg, state_next;
  logic [N_TGT-1:0] tsel_reg;
  logic [ADR_W-1:0] adr_reg;
  logic [DAT_W-1:0] dat_w_reg;
  logic [SEL_W-1:0] bsel_reg;
  logic             we_reg;

  logic [N_TGT-1:0] dec_sel;
  logic             dec_hit;
  logic             req;
  logic             resp;
  logic             expire;

  logic [N_TGT-1:0] t_cyc_c;
  logic [N_TGT-1:0] t_we_c;
  logic             i_ack_c;
  logic             i_err_c;
  logic [DAT_W-1:0] i_dat_r_c;

  wb_interconnect_adr_dec #(
    .N_TGT      (N_TGT),
    .ADR_W      (ADR_W),
    .T_ADR      (T_ADR),
    .T_ADR_MASK (T_ADR_MASK)
  ) u_adr_dec (
    .adr (bus.i_adr),
    .sel (dec_sel),
    .hit (dec_hit)
  );

  assign req  = bus.i_cyc & bus.i_stb;
  assign resp = |((bus.t_ack | bus.t_err) & tsel_reg);

`ifdef WB_INTERCONNECT_TGT_SEL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_reg;

  // Count cycles spent waiting in ACTIVE; restarts from zero on every new access.
  always_ff @(posedge clk) begin
    if (rst || state_reg != ACTIVE) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // A response arriving on the expiry cycle takes priority over the timeout.
  assign expire = (cnt_reg == CNT_W'(TIMEOUT - 1)) & ~resp;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expire         = 1'b0;
`endif

  // Capture the request and its decoded target when a new cycle starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      tsel_reg  <= '0;
      adr_reg   <= '0;
      dat_w_reg <= '0;
      bsel_reg  <= '0;
      we_reg    <= 1'b0;
    end else if (state_reg == IDLE && req) begin
      tsel_reg  <= dec_sel;
      adr_reg   <= bus.i_adr;
      dat_w_reg <= bus.i_dat_w;
      bsel_reg  <= bus.i_sel;
      we_reg    <= bus.i_we;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state plus routed control and response signals.
  always_comb begin
    state_next = state_reg;
    t_cyc_c    = '0;
    t_we_c     = '0;
    i_ack_c    = 1'b0;
    i_err_c    = 1'b0;
    i_dat_r_c  = '0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = dec_hit ? ACTIVE : ERR;
        end
      end
      ACTIVE: begin
        if (bus.i_cyc && !expire) begin
          t_cyc_c = tsel_reg;
        end
        t_we_c = we_reg ? tsel_reg : '0;
        // An aborted cycle must not leak a response back to the initiator.
        if (bus.i_cyc) begin
          i_ack_c = |(bus.t_ack & tsel_reg);
          i_err_c = |(bus.t_err & tsel_reg);
        end
        for (int k = 0; k < N_TGT; k++) begin
          if (tsel_reg[k]) begin
            i_dat_r_c = bus.t_dat_r[slice_lo(k, DAT_W) +: DAT_W];
          end
        end
        if (!bus.i_cyc || resp) begin
          state_next = IDLE;
        end else if (expire) begin
          state_next = ERR;
        end
      end
      ERR: begin
        i_err_c    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.t_cyc   = t_cyc_c;
  assign bus.t_stb   = t_cyc_c;
  assign bus.t_we    = t_we_c;
  assign bus.t_adr   = {N_TGT{adr_reg}};
  assign bus.t_dat_w = {N_TGT{dat_w_reg}};
  assign bus.t_sel   = {N_TGT{bsel_reg}};
  assign bus.i_ack   = i_ack_c;
  assign bus.i_err   = i_err_c;
  assign bus.i_dat_r = i_dat_r_c;

endmodule

// File: tb/tb_wb_interconnect_tgt_sel.sv
// Self-checking bench for wb_interconnect_tgt_sel: two targets at
// 0x1xxx_xxxx and 0x2xxx_xxxx, directed scenarios followed by random
// accesses, all checked against a cycle-level reference derived from
// the address map and the response timing rules.
module tb_wb_interconnect_tgt_sel;

  localparam int N_TGT = 2;
  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam logic [63:0] T_ADR  = {32'h2000_0000, 32'h1000_0000};
  localparam logic [63:0] T_MASK = {2{32'hF000_0000}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  wb_interconnect_tgt_sel_if #(.N_TGT(N_TGT), .ADR_W(ADR_W), .DAT_W(DAT_W)) bus ();

  wb_interconnect_tgt_sel #(
    .N_TGT      (N_TGT),
    .ADR_W      (ADR_W),
    .DAT_W      (DAT_W),
    .T_ADR      (T_ADR),
    .T_ADR_MASK (T_MASK),
    .TIMEOUT    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference address map: top nibble 1 -> target 0, 2 -> target 1, else unmapped.
  function automatic int ref_decode(input logic [31:0] adr);
    case (adr[31:28])
      4'h1:    return 0;
      4'h2:    return 1;
      default: return -1;
    endcase
  endfunction

  task automatic randomize_rdata();
    bus.t_dat_r = {$urandom(), $urandom()};
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tcyc"}, 64'(bus.t_cyc), 64'(0));
    check({tag, "_tstb"}, 64'(bus.t_stb), 64'(0));
    check({tag, "_twe"},  64'(bus.t_we), 64'(0));
    check({tag, "_iack"}, 64'(bus.i_ack), 64'(0));
    check({tag, "_ierr"}, 64'(bus.i_err), 64'(0));
    check({tag, "_idatr"}, 64'(bus.i_dat_r), 64'(0));
  endtask

  task automatic drive_req(input logic [31:0] adr, input logic we,
                           input logic [31:0] wdat, input logic [3:0] sel);
    bus.i_adr   = adr;
    bus.i_we    = we;
    bus.i_dat_w = wdat;
    bus.i_sel   = sel;
    bus.i_cyc   = 1'b1;
    bus.i_stb   = 1'b1;
  endtask

  task automatic release_bus();
    bus.i_cyc = 1'b0;
    bus.i_stb = 1'b0;
    bus.t_ack = '0;
    bus.t_err = '0;
  endtask

  // Full classic cycle: request in an idle cycle, target answers after wait_n stalls.
  task automatic access(input string tag, input logic [31:0] adr, input logic we,
                        input logic [31:0] wdat, input logic [3:0] sel,
                        input int wait_n, input logic rsp_err, input logic [31:0] rdata);
    int         tgt;
    logic [1:0] oh;
    logic       last;
    logic [31:0] exp_r;
    tgt = ref_decode(adr);
    drive_req(adr, we, wdat, sel);
    randomize_rdata();
    @(negedge clk);
    check_idle({tag, "_req"});
    @(posedge clk); #1;
    if (tgt < 0) begin
      randomize_rdata();
      @(negedge clk);
      check({tag, "_unm_ierr"}, 64'(bus.i_err), 64'(1));
      check({tag, "_unm_iack"}, 64'(bus.i_ack), 64'(0));
      check({tag, "_unm_tcyc"}, 64'(bus.t_cyc), 64'(0));
      check({tag, "_unm_idatr"}, 64'(bus.i_dat_r), 64'(0));
      @(posedge clk); #1;
      release_bus();
      $display("txn %s adr=%08h unmapped -> err", tag, adr);
      return;
    end
    oh = 2'(1) << tgt;
    for (int c = 1; c <= wait_n + 1; c++) begin
      last = (c == wait_n + 1);
      randomize_rdata();
      if (last) bus.t_dat_r[tgt*32 +: 32] = rdata;
      exp_r = bus.t_dat_r[tgt*32 +: 32];
      bus.t_ack = (last && !rsp_err) ? oh : 2'b00;
      bus.t_err = (last && rsp_err) ? oh : 2'b00;
      @(negedge clk);
      check({tag, "_tcyc"}, 64'(bus.t_cyc), 64'(oh));
      check({tag, "_tstb"}, 64'(bus.t_stb), 64'(oh));
      check({tag, "_twe"},  64'(bus.t_we), 64'(we ? oh : 2'b00));
      check({tag, "_iack"}, 64'(bus.i_ack), 64'(last && !rsp_err));
      check({tag, "_ierr"}, 64'(bus.i_err), 64'(last && rsp_err));
      check({tag, "_idatr"}, 64'(bus.i_dat_r), 64'(exp_r));
      if (c == 1) begin
        check({tag, "_tadr"}, bus.t_adr, {adr, adr});
        check({tag, "_tdatw"}, bus.t_dat_w, {wdat, wdat});
        check({tag, "_tsel"}, 64'(bus.t_sel), 64'({sel, sel}));
      end
      @(posedge clk); #1;
    end
    release_bus();
    $display("txn %s adr=%08h we=%0d tgt=%0d wait=%0d rsp=%s", tag, adr, we, tgt, wait_n,
             rsp_err ? "err" : "ack");
  endtask

  // Initiator abandons a stalled access to target 0 in its third active cycle.
  task automatic abort_access(input logic [31:0] adr);
    drive_req(adr, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    check_idle("abort_req");
    @(posedge clk); #1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check("abort_stall_tcyc", 64'(bus.t_cyc), 64'(2'b01));
      check("abort_stall_iack", 64'(bus.i_ack), 64'(0));
      @(posedge clk); #1;
    end
    bus.i_cyc = 1'b0;
    bus.i_stb = 1'b0;
    @(negedge clk);
    check("abort_tcyc", 64'(bus.t_cyc), 64'(0));
    check("abort_tstb", 64'(bus.t_stb), 64'(0));
    check("abort_iack", 64'(bus.i_ack), 64'(0));
    check("abort_ierr", 64'(bus.i_err), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_after_ierr", 64'(bus.i_err), 64'(0));
    check("abort_after_iack", 64'(bus.i_ack), 64'(0));
    @(posedge clk); #1;
    $display("txn abort adr=%08h dropped after 2 stall cycles", adr);
  endtask

  // Target 1 never answers.
  task automatic stall_access();
    drive_req(32'h2000_0040, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    check_idle("stall_req");
    @(posedge clk); #1;
`ifdef WB_INTERCONNECT_TGT_SEL_TIMEOUT_EN
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      check("to_wait_tcyc", 64'(bus.t_cyc), 64'(2'b10));
      check("to_wait_ierr", 64'(bus.i_err), 64'(0));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("to_expire_tcyc", 64'(bus.t_cyc), 64'(0));
    check("to_expire_ierr", 64'(bus.i_err), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("to_err_ierr", 64'(bus.i_err), 64'(1));
    check("to_err_tcyc", 64'(bus.t_cyc), 64'(0));
    @(posedge clk); #1;
    release_bus();
    $display("txn timeout adr=20000040 errored after 16 cycles");
    // Response on the expiry cycle wins over the timeout.
    drive_req(32'h2000_0044, 1'b0, 32'h0, 4'hF);
    @(posedge clk); #1;
    for (int c = 1; c <= 15; c++) @(posedge clk);
    #1;
    bus.t_ack = 2'b10;
    @(negedge clk);
    check("to_race_iack", 64'(bus.i_ack), 64'(1));
    check("to_race_ierr", 64'(bus.i_err), 64'(0));
    @(posedge clk); #1;
    release_bus();
    @(negedge clk);
    check("to_race_after_ierr", 64'(bus.i_err), 64'(0));
    @(posedge clk); #1;
    $display("txn timeout_race adr=20000044 ack on expiry cycle");
`else
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      check("nto_wait_tcyc", 64'(bus.t_cyc), 64'(2'b10));
      check("nto_wait_ierr", 64'(bus.i_err), 64'(0));
      @(posedge clk); #1;
    end
    bus.i_cyc = 1'b0;
    bus.i_stb = 1'b0;
    @(negedge clk);
    check("nto_abort_tcyc", 64'(bus.t_cyc), 64'(0));
    @(posedge clk); #1;
    $display("txn stall adr=20000040 still waiting after 100 cycles, aborted");
`endif
  endtask

  // Reset hits during an active access; i_cyc stays high afterwards so a
  // router that ignored reset would still be driving t_cyc.
  task automatic reset_mid();
    drive_req(32'h1000_0008, 1'b1, 32'hCAFE_F00D, 4'h3);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid_active_tcyc", 64'(bus.t_cyc), 64'(2'b01));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_pre_tcyc", 64'(bus.t_cyc), 64'(2'b01));
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_stb = 1'b0;
    randomize_rdata();
    @(negedge clk);
    check_idle("rstmid_post");
    @(posedge clk); #1;
    bus.i_cyc = 1'b0;
    $display("txn reset_mid adr=10000008 reset during active cycle");
  endtask

  initial begin
    logic [31:0] r_adr;
    logic [31:0] r_low;
    logic [3:0]  nib;
    int          pick;
    bus.i_adr   = '0;
    bus.i_dat_w = '0;
    bus.i_we    = 1'b0;
    bus.i_sel   = '0;
    bus.i_cyc   = 1'b0;
    bus.i_stb   = 1'b0;
    bus.t_dat_r = '0;
    bus.t_ack   = '0;
    bus.t_err   = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    randomize_rdata();
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    access("wr_t0", 32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0);
    access("rd_t1", 32'h2000_0010, 1'b0, 32'h0, 4'hF, 3, 1'b0, 32'h1234_5678);
    access("unmapped", 32'h3000_0000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h0);
    access("t0_err", 32'h1000_0100, 1'b1, 32'h0BAD_0BAD, 4'h1, 1, 1'b1, 32'h0);
    abort_access(32'h1000_0020);
    access("post_abort", 32'h2000_0008, 1'b1, 32'h5555_AAAA, 4'hC, 0, 1'b0, 32'h0);
    stall_access();
    reset_mid();
    access("post_rst", 32'h1000_0000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'hA5A5_5A5A);

    for (int i = 0; i < 40; i++) begin
      pick  = $urandom_range(0, 3);
      r_low = $urandom();
      nib   = (pick == 0) ? 4'h1 : (pick == 1) ? 4'h2 :
              (pick == 2) ? 4'(($urandom_range(3, 15))) : 4'h0;
      r_adr = {nib, r_low[27:0]};
      access($sformatf("rnd%0d", i), r_adr, 1'($urandom_range(0, 1)), $urandom(),
             4'($urandom_range(0, 15)), $urandom_range(0, 4),
             ($urandom_range(0, 3) == 0), $urandom());
    end

    @(negedge clk);
    check_idle("final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_interconnect_tgt_sel.md
# wb_interconnect_tgt_sel

Single-initiator to N-target Wishbone address decoder and router: the target-side counterpart of the interconnect arbiter. It sits downstream of arbitration, takes the granted initiator's classic-cycle bus, decodes the address to one of N_TGT target ports, and routes the cycle there. It returns ack/err/read data back to the initiator, and generates an error response for unmapped addresses.

## Interface
- N_TGT, 2, number of target ports (≥1)
- ADR_W, 32, address width
- DAT_W, 32, data width (multiple of 8)
- T_ADR, {N_TGT{ADR_W'h0}}, flattened per-target base addresses; target k at [k*ADR_W +: ADR_W]
- T_ADR_MASK, {N_TGT{ADR_W'h0}}, flattened per-target decode masks, same packing
- TIMEOUT, 256, cycles before an unanswered cycle is errored (timeout build only; ≥2)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- i_adr  in  ADR_W  initiator address
- i_dat_w  in  DAT_W  initiator write data
- i_dat_r  out  DAT_W  read data to initiator
- i_cyc, i_stb, i_we  in  1 each  initiator cycle/strobe/write-enable
- i_sel  in  DAT_W/8  byte selects
- i_ack, i_err  out  1 each  responses to initiator
- t_adr  out  N_TGT*ADR_W  per-target address (broadcast copy of latched i_adr)
- t_dat_w  out  N_TGT*DAT_W  per-target write data (broadcast)
- t_dat_r  in  N_TGT*DAT_W  per-target read data
- t_cyc, t_stb, t_we  out  N_TGT each  per-target control; only selected bit may be high
- t_sel  out  N_TGT*DAT_W/8  per-target byte selects (broadcast)
- t_ack, t_err  in  N_TGT each  per-target responses

## Operation
- Match k: (i_adr & mask_k) == (base_k & mask_k). Multiple matches: lowest k wins. No match: unmapped.
- States: IDLE, ACTIVE, ERR.
- IDLE: when i_cyc & i_stb, latch the one-hot select, i_adr, i_we, i_sel, and i_dat_w. If mapped, go to ACTIVE; otherwise go to ERR.
- ACTIVE: t_cyc[sel] = t_stb[sel] = i_cyc; t_we[sel] = latched we. i_ack = t_ack[sel], i_err = t_err[sel], i_dat_r = t_dat_r[sel], all combinational.
- ACTIVE exit: t_ack[sel] | t_err[sel] returns to IDLE next edge.
- ERR: i_err = 1 for exactly one cycle, no t_cyc raised, then IDLE.
- Abort: i_cyc low in ACTIVE drops t_cyc/t_stb combinationally the same cycle, returns to IDLE, and produces no response.
- Response outputs are 0 outside ACTIVE/ERR. i_dat_r is 0 when not in ACTIVE.

## Timing
- Reset values: state IDLE; all t_cyc/t_stb/t_we = 0; i_ack = i_err = 0; i_dat_r = 0; latched select = 0.
- Request seen at edge n; target sees t_cyc/t_stb from cycle n+1.
- Target ack at cycle m reaches the initiator in cycle m (zero-latency return).
- Minimum cycle: 2 clocks for a zero-wait target. Back-to-back: next request is decoded in the IDLE cycle after the response, with 1 dead cycle.
- Unmapped: i_err in cycle n+1.
- The initiator must hold i_cyc/i_stb until ack/err (classic Wishbone). A held stb in the post-response IDLE cycle is treated as a new request.
- rst mid-transaction: outputs are forced to reset values at the next edge, with no response generated.

## Configuration
- WB_INTERCONNECT_TGT_SEL_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT) clears on IDLE→ACTIVE and increments each ACTIVE cycle.
  - When it reaches TIMEOUT-1 with no t_ack/t_err: drop t_cyc, go to ERR, and deliver i_err the following cycle.
  - A target response in the same cycle as expiry wins, and no timeout error is raised.
- WB_INTERCONNECT_TGT_SEL_TIMEOUT_EN undefined: no counter; ACTIVE waits indefinitely; TIMEOUT parameter unused.

## Structure
- Shared package wb_interconnect_pkg: state enum (IDLE/ACTIVE/ERR); per-index slice helper for flattened vectors.
- Sub-module wb_interconnect_adr_dec: purely combinational; i_adr + T_ADR/T_ADR_MASK produce the one-hot select and a hit flag. It is reusable by future multi-initiator crossbars.

## Test plan
Bench config: N_TGT=2, T_ADR={32'h2000_0000, 32'h1000_0000}, masks 32'hF000_0000.
- Write 0x1000_0004 with data 0xDEADBEEF, sel 4'hF; t0 acks on its first cycle → t_cyc[0]=1 at n+1, t_dat_w=0xDEADBEEF, i_ack=1 at n+1, t_cyc[1] never set, IDLE at n+2.
- Read 0x2000_0010; t1 returns 0x12345678 after 3 wait cycles → i_dat_r=0x12345678 with i_ack at n+4, single ack pulse.
- Access 0x3000_0000 → i_err=1 for one cycle at n+1, t_cyc=2'b00 throughout.
- Initiator drops i_cyc two cycles into a stalled t0 access → t_cyc[0]=0 in the same cycle, no i_ack/i_err, next request decodes normally.
- Timeout build, TIMEOUT=16, t1 never responds → t_cyc[1] drops at cycle n+16, i_err pulses at n+17. Non-timeout build: still waiting at n+100.
- rst asserted mid-ACTIVE → all outputs 0 after the edge, state IDLE; a following access to 0x1000_0000 completes normally.
